ctrl_word_encoder: RTL
======================

Name: ctrl_word_encoder

Overview:
- Inverse of the 7-in/26-out control decoder: takes a decoded CTRL_W-bit control word and returns the CODE_W-bit opcode that produces it.
- Mapping lives in a host-loadable table of 2^CODE_W entries, each holding a control word and a valid bit.
- Search is sequential, LANES entries per cycle. The lowest matching index wins.
- Used in the control-path regression flow to re-encode control vectors and flag unencodable ones.

Parameters:
- CODE_W, 7: opcode width. Table depth N = 2^CODE_W.
- CTRL_W, 26: control word width.
- LANES, 1: entries compared per cycle. Power of two, 1..N.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  CODE_W  table write index.
- tbl_data  in  CTRL_W  control word written to the entry.
- tbl_clr  in  1  invalidate all entries.
- tbl_busy  out  1  high while a search is in progress (state SEARCH).
- tbl_err  out  1  sticky flag: a table write or clear was attempted while busy.
- in_valid  in  1  control word present.
- in_ready  out  1  encoder can accept a word.
- in_word  in  CTRL_W  control word to encode.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_code  out  CODE_W  encoded opcode; 0 on a miss.
- out_miss  out  1  no valid entry matched.
- miss_cnt  out  8  saturating count of miss results delivered.

Behaviour:
- Reset (asynchronous):
  - state IDLE; all entry valid bits cleared.
  - in_ready=1; out_valid, out_code, out_miss, tbl_busy, tbl_err, miss_cnt all 0.
  - Entry data contents are don't-care.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_word, set block index k=0, go to SEARCH.
  - SEARCH: in_ready=0, tbl_busy=1. Each cycle compare entries k*LANES .. k*LANES+LANES-1 against the latched word. An entry matches only if its valid bit is 1 and its data equals the word.
    - Any match: out_code = lowest matching index, out_miss=0, go to OUT.
    - No match and k = N/LANES-1: out_code=0, out_miss=1, go to OUT.
    - Otherwise k=k+1.
  - OUT: out_valid=1; out_code and out_miss held stable. On out_ready, drop out_valid, go to IDLE; in_ready rises in that same transition. If out_miss=1, increment miss_cnt (saturates at 255).
- Latency: handshake at edge E0; a match at index i appears with out_valid=1 after edge E(floor(i/LANES)+1). A miss appears after E(N/LANES). There is no bypass path.
- Throughput: one word at a time. The next word is accepted no earlier than the edge after the out handshake.
- Table writes:
  - When not busy: tbl_we sets entry[tbl_addr] to tbl_data with valid=1 at the edge; tbl_clr clears every valid bit at the edge.
  - If tbl_clr and tbl_we occur in the same cycle, the clear applies first, then the write, so the written entry ends up valid.
  - Any tbl_we or tbl_clr while tbl_busy=1 is dropped and sets tbl_err=1. tbl_err clears only on reset.
  - Writes are allowed in OUT; they do not affect the held result.
- Duplicates: identical data in several valid entries returns the lowest index.
- The latched word is independent of in_word after acceptance.
- A reset asserted mid-SEARCH or mid-OUT aborts immediately. The result is lost and miss_cnt is not incremented.

Test Plan:
- Reset, then submit in_word=26'h0000001 with the table empty -> after N/LANES search cycles (128 with defaults), out_valid=1, out_miss=1, out_code=0; miss_cnt goes to 1 after out_ready.
- Write entry 5=26'h2A0001 and entry 9=26'h2A0001, submit 26'h2A0001 with LANES=1 -> out_code=5, out_miss=0, out_valid after edge E6.
- LANES=4, entry 127=26'h3FFFFFF, submit that word -> out_code=127 after edge E32.
- Hold out_ready=0 for 10 cycles in OUT -> out_code/out_valid stable and in_ready=0; raise out_ready -> in_ready=1 on the next cycle.
- tbl_we during SEARCH -> the write is dropped and tbl_err=1; re-searching the same word still misses. Then apply tbl_clr and tbl_we to entry 3 in the same idle cycle -> only entry 3 is valid.
- Assert rst mid-SEARCH -> out_valid=0 and in_ready=1 the cycle after deassert, all entries invalid, miss_cnt unchanged at 0.

Source files
------------

// File: rtl/ctrl_word_encoder.sv
// rtl/ctrl_word_encoder.sv - re-encodes a control word into its opcode by searching a loadable table
module ctrl_word_encoder #(
  parameter int CODE_W = 7,
  parameter int CTRL_W = 26,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [CODE_W-1:0] tbl_addr,
  input  logic [CTRL_W-1:0] tbl_data,
  input  logic              tbl_clr,
  output logic              tbl_busy,
  output logic              tbl_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_miss,
  output logic [7:0]        miss_cnt
);

  localparam int N  = 1 << CODE_W;
  localparam int NB = N / LANES;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CTRL_W-1:0]   word_q, word_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                miss_q, miss_d;
  logic [7:0]          miss_cnt_q, miss_cnt_d;
  logic                err_q, err_d;
  logic [N-1:0]        valid_q, valid_d;
  logic [CTRL_W-1:0]   data_q [N];

  logic                busy;
  logic                wr_ok;
  logic                hit;
  logic [CODE_W-1:0]   hit_code;
  logic [CODE_W-1:0]   idx;

  assign busy  = (state_q == SEARCH);
  assign wr_ok = tbl_we && !busy;

  // Scan lanes from high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_code = '0;
    idx      = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      idx = CODE_W'(int'(k_q) * LANES + l);
      if (valid_q[idx] && (data_q[idx] == word_q)) begin
        hit      = 1'b1;
        hit_code = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    word_d     = word_q;
    code_d     = code_q;
    miss_d     = miss_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = err_q;
    valid_d    = valid_q;

    if (busy && (tbl_we || tbl_clr)) begin
      err_d = 1'b1;
    end else begin
      if (tbl_clr) valid_d = '0;
      if (tbl_we)  valid_d[tbl_addr] = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          k_d     = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          code_d  = hit_code;
          miss_d  = 1'b0;
          state_d = OUT;
        end else if (k_q == KW'(NB - 1)) begin
          code_d  = '0;
          miss_d  = 1'b1;
          state_d = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          if (miss_q && (miss_cnt_q != 8'hFF)) miss_cnt_d = miss_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      word_q     <= '0;
      code_q     <= '0;
      miss_q     <= 1'b0;
      miss_cnt_q <= 8'd0;
      err_q      <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      word_q     <= word_d;
      code_q     <= code_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  // Entry payloads need no reset: an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_ok) data_q[tbl_addr] <= tbl_data;
  end

  assign tbl_busy  = busy;
  assign tbl_err   = err_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_code  = code_q;
  assign out_miss  = miss_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
